// File: rtl/mips_cpu_hilo_mult_ctrl_if.sv
// Execute-stage / multiplier bundle for the HI/LO multiply sequencer.
// The slave modport is the sequencer; the master side is its environment.
interface mips_cpu_hilo_mult_ctrl_if;
    logic        op_valid;
    logic [1:0]  op_code;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        read_hi;
    logic        read_lo;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_sign;
    logic [63:0] mul_product;

    modport master (
        output op_valid, op_code, rs_data, rt_data, read_hi, read_lo, mul_product,
        input  stall, busy, hi, lo, mul_a, mul_b, mul_sign
    );

    modport slave (
        input  op_valid, op_code, rs_data, rt_data, read_hi, read_lo, mul_product,
        output stall, busy, hi, lo, mul_a, mul_b, mul_sign
    );
endinterface

// File: rtl/mips_cpu_hilo_mult_ctrl.sv
// HI/LO register owner and sequencer for a fixed-latency external multiplier.
// Operands are held for the whole run; the product lands in HI/LO on the last RUN edge.
module mips_cpu_hilo_mult_ctrl #(
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    mips_cpu_hilo_mult_ctrl_if.slave   bus
);
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] LAT_C = 4'(MUL_LATENCY);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic        mul_sign_q, mul_sign_d;
    logic        stall_s;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            busy_q     <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            mul_a_q    <= 32'd0;
            mul_b_q    <= 32'd0;
            mul_sign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            mul_sign_q <= mul_sign_d;
        end
    end

    // Next-state: accept ops in IDLE, count down in RUN and write back the product.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        mul_sign_d = mul_sign_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    case (bus.op_code)
                        2'b00, 2'b01: begin
                            mul_a_d    = bus.rs_data;
                            mul_b_d    = bus.rt_data;
                            mul_sign_d = (bus.op_code == 2'b00);
                            cnt_d      = LAT_C;
                            busy_d     = 1'b1;
                            state_d    = ST_RUN;
                        end
                        2'b10:   hi_d = bus.rs_data;
                        2'b11:   lo_d = bus.rs_data;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 4'd1;
                // A zero count can only come from corruption; finish rather than wrap.
                if (cnt_q <= 4'd1) begin
                    hi_d    = bus.mul_product[63:32];
                    lo_d    = bus.mul_product[31:0];
                    busy_d  = 1'b0;
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // HI/LO are stale for every RUN cycle, so any consumer or new op must wait.
    always_comb begin
        stall_s = busy_q & (bus.op_valid | bus.read_hi | bus.read_lo);
    end

    assign bus.stall    = stall_s;
    assign bus.busy     = busy_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.mul_a    = mul_a_q;
    assign bus.mul_b    = mul_b_q;
    assign bus.mul_sign = mul_sign_q;
endmodule

// File: tb/tb_mips_cpu_hilo_mult_ctrl.sv
// Bench for the HI/LO multiply sequencer at latencies 2 and 5, sharing one stimulus stream.
// Each instance has its own multiplier model, reference model, result queue and monitor.
module tb_mips_cpu_hilo_mult_ctrl;
    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        op_valid = 1'b0;
    logic [1:0]  op_code  = 2'b00;
    logic [31:0] rs_data  = 32'd0;
    logic [31:0] rt_data  = 32'd0;
    logic        read_hi  = 1'b0;
    logic        read_lo  = 1'b0;
    int          n_pass   = 0;
    int          n_total  = 0;

    always #5 clk = ~clk;

    function automatic logic [63:0] prod_of(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (s) return sa * sb;
        return {32'd0, a} * {32'd0, b};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_lat
        localparam int LAT = (g == 0) ? 2 : 5;

        mips_cpu_hilo_mult_ctrl_if bus();
        assign bus.op_valid = op_valid;
        assign bus.op_code  = op_code;
        assign bus.rs_data  = rs_data;
        assign bus.rt_data  = rt_data;
        assign bus.read_hi  = read_hi;
        assign bus.read_lo  = read_lo;

        mips_cpu_hilo_mult_ctrl #(.MUL_LATENCY(LAT)) dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (bus)
        );

        // Multiplier: product usable at the LAT-th edge after the operands are registered.
        logic [63:0] pipe [LAT];
        always @(posedge clk) begin
            pipe[0] <= prod_of(bus.mul_a, bus.mul_b, bus.mul_sign);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign bus.mul_product = pipe[LAT-2];

        int          m_left = 0;
        logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_a = 32'd0, m_b = 32'd0;
        logic        m_sign = 1'b0;
        logic [63:0] m_prod = 64'd0;
        logic [63:0] exp_q [$];
        int          run_len = 0;
        logic        busy_prev = 1'b0;
        logic [63:0] e;

        // Reference model: architectural rules applied once per edge.
        always @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                m_left <= 0; m_hi <= 32'd0; m_lo <= 32'd0;
                m_a <= 32'd0; m_b <= 32'd0; m_sign <= 1'b0; m_prod <= 64'd0;
                exp_q.delete();
            end else if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) {m_hi, m_lo} <= m_prod;
            end else if (op_valid) begin
                if (op_code[1] == 1'b0) begin
                    m_a    <= rs_data;
                    m_b    <= rt_data;
                    m_sign <= (op_code == 2'b00);
                    m_prod <= prod_of(rs_data, rt_data, op_code == 2'b00);
                    m_left <= LAT;
                    exp_q.push_back(prod_of(rs_data, rt_data, op_code == 2'b00));
                end else if (op_code == 2'b10) begin
                    m_hi <= rs_data;
                end else begin
                    m_lo <= rs_data;
                end
            end
        end

        task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
            n_total++;
            if (act !== exp)
                $display("FAIL L%0d %s at %0t: got %h expected %h", LAT, name, $time, act, exp);
            else
                n_pass++;
        endtask

        // Monitor: per-cycle checks plus a queue pop whenever a multiply completes.
        initial begin
            forever begin
                @(negedge clk);
                if (!reset_n) begin
                    busy_prev = 1'b0;
                    run_len   = 0;
                end else begin
                    chk("stall", bus.stall, (m_left != 0) && (op_valid || read_hi || read_lo));
                    chk("busy", bus.busy, m_left != 0);
                    chk("hi", bus.hi, m_hi);
                    chk("lo", bus.lo, m_lo);
                    chk("mul_a", bus.mul_a, m_a);
                    chk("mul_b", bus.mul_b, m_b);
                    chk("mul_sign", bus.mul_sign, m_sign);
                    if (bus.busy) run_len++;
                    if (busy_prev && !bus.busy) begin
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk("hilo_result", {bus.hi, bus.lo}, e);
                        end else begin
                            chk("result_queue", 64'(exp_q.size()), 64'd1);
                        end
                        chk("busy_len", 64'(run_len), 64'(LAT));
                        run_len = 0;
                    end
                    busy_prev = bus.busy;
                end
            end
        end
    end

    task automatic step(input logic v, input logic [1:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic rh, input logic rl);
        op_valid = v; op_code = c; rs_data = a; rt_data = b; read_hi = rh; read_lo = rl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    logic [31:0] pick [6];

    initial begin
        pick = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFD};
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(2);
        step(1'b1, 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        idle(7);
        step(1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(7);
        step(1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(7);
        step(1'b1, 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 2'b00, 32'd7, 32'd6, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 2'b11, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 2'b10, 32'hA5A5_A5A5, 32'd0, 1'b1, 1'b0);
        idle(1);
        step(1'b1, 2'b00, 32'd3, 32'd3, 1'b0, 1'b0);
        idle(1);
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(8);
        step(1'b1, 2'b01, 32'd100, 32'd200, 1'b0, 1'b0);
        idle(8);
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(2, 0) == 0,
                 2'($urandom_range(3, 0)),
                 ($urandom_range(3, 0) == 0) ? pick[$urandom_range(5, 0)] : $urandom,
                 ($urandom_range(3, 0) == 0) ? pick[$urandom_range(5, 0)] : $urandom,
                 $urandom_range(3, 0) == 0,
                 $urandom_range(3, 0) == 0);
        end
        idle(10);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mips_cpu_hilo_mult_ctrl.md
Name: mips_cpu_hilo_mult_ctrl

Overview:
Sequencer and HI/LO register owner for the CPU's multi-cycle signed/unsigned multiplier.
- Accepts MULT/MULTU/MTHI/MTLO from the execute stage.
- Holds the multiplier operands stable for the multiplier's fixed pipeline latency, then captures the 64-bit product into HI/LO.
- Asserts a stall to the pipeline whenever an instruction touches HI/LO or the multiplier while a multiply is in flight.

Parameters:
MUL_LATENCY, 2, clock edges from operands registered at the multiplier inputs to a valid mul_product; legal range 1..15.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
op_valid  input  1  execute stage presents a HI/LO-class op this cycle
op_code  input  2  00 MULT (signed), 01 MULTU, 10 MTHI, 11 MTLO
rs_data  input  32  multiplicand, or write data for MTHI/MTLO
rt_data  input  32  multiplier operand
read_hi  input  1  MFHI in execute stage
read_lo  input  1  MFLO in execute stage
stall  output  1  combinational; pipeline must hold the current instruction
busy  output  1  registered; multiply in flight
hi  output  32  HI register
lo  output  32  LO register
mul_a  output  32  registered operand to multiplier a
mul_b  output  32  registered operand to multiplier b
mul_sign  output  1  registered sign select to multiplier
mul_product  input  64  multiplier result, valid MUL_LATENCY edges after mul_a/mul_b/mul_sign change

Behaviour:
- Reset (async, reset_n=0): state=IDLE, cnt=0, busy=0, hi=lo=0, mul_a=mul_b=0, mul_sign=0. Asserting reset mid-RUN aborts the multiply; hi/lo are cleared, not written with a partial result.
- States: IDLE, RUN. cnt is a 4-bit down counter.
- IDLE, op_valid=1, op_code MULT/MULTU:
  - Next edge: mul_a<=rs_data, mul_b<=rt_data, mul_sign<=(op_code==00), cnt<=MUL_LATENCY, busy<=1, state<=RUN.
  - stall=0, so the op is accepted that cycle.
- IDLE, op_valid=1, MTHI: hi<=rs_data at next edge. MTLO: lo<=rs_data. stall=0. Multiplier registers are unchanged.
- RUN: cnt decrements every edge. On the edge where cnt==1:
  - hi<=mul_product[63:32], lo<=mul_product[31:0], busy<=0, state<=IDLE.
  - busy is therefore high for exactly MUL_LATENCY cycles; the new hi/lo is visible the cycle after busy falls.
- Operand stability: mul_a/mul_b/mul_sign are held constant throughout RUN and keep their last value in IDLE.
- stall = busy & (op_valid | read_hi | read_lo).
  - Asserted in every RUN cycle, including the final one, because HI/LO are not yet written.
  - A stalled op is not accepted and has no side effect. The pipeline re-presents it and it is accepted in the first IDLE cycle.
- read_hi/read_lo in IDLE: stall=0; the consumer samples the current hi/lo outputs.
- Simultaneous read_hi/read_lo and op_valid in IDLE (e.g. MFHI in execute while a later op is also flagged): the read sees the pre-update hi/lo and the op is accepted normally. A MTHI with read_hi in the same cycle returns the old HI.
- Signed handling is delegated entirely to the multiplier via mul_sign. This block performs no arithmetic on the product.
- No back-to-back overlap: a second multiply can start at the earliest in the cycle following the HI/LO write.

Test Plan:
1. Reset, then MULT rs=0xFFFFFFFD (-3), rt=5, MUL_LATENCY=2 -> busy high 2 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
2. MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Same operands with MULT -> hi=0x00000000, lo=0x00000001.
3. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000. read_hi asserted in each RUN cycle -> stall=1 in both cycles, 0 in the first IDLE cycle, when hi reads 0x40000000.
4. MULT 7x6 immediately followed by MTLO rs=0x12345678 held at op_valid -> stall=1 for 2 cycles, then lo=42 and, one edge later, lo=0x12345678, hi=0.
5. MTHI 0xA5A5A5A5 and read_hi together in IDLE -> stall=0, read sees old hi=0, hi=0xA5A5A5A5 next cycle. Then MULT 3x3 with reset_n pulsed low during RUN -> busy=0, hi=lo=0, state IDLE, no later write.
6. MUL_LATENCY=5 build, MULTU 100x200 -> busy exactly 5 cycles, lo=20000, hi=0; mul_a/mul_b are constant throughout.
